// File: rtl/cache_pkg.sv
// Shared types and constants for the arbitro_cache controller slice.
package cache_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 3;

    localparam logic PORTA0 = 1'b0;
    localparam logic PORTA1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ACESSO,
        ESPERA_WB,
        ESPERA_MISS,
        RESPOSTA
    } estado_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Two-input round-robin selector: ptr breaks ties, a lone request always wins.
module arbitro_rr
    import cache_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    input  logic habilita,
    output logic valido,
    output logic vencedor
);

    always_comb begin
        valido   = habilita & (req0 | req1);
        vencedor = PORTA0;
        if (req0 && req1) begin
            vencedor = ptr;
        end else if (req1) begin
            vencedor = PORTA1;
        end
    end

endmodule

// File: rtl/arbitro_cache.sv
// Shares one memoriaCache between two requesters with fixed hit/miss/write-back latencies.
// Define ARBITRO_CONTADORES_EN to enable saturating hit/miss/write-back counters.
module arbitro_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MISS_LAT = 2,
    parameter int WB_LAT   = 2,
    parameter int MAX_TENT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wren0,
    input  logic              wren1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [ADDR_W-1:0] address0,
    input  logic [ADDR_W-1:0] address1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] dadoCPU0,
    output logic [DATA_W-1:0] dadoCPU1,
    output logic              erro,
    output logic              cache_wren,
    output logic [DATA_W-1:0] cache_data,
    output logic [ADDR_W-1:0] cache_address,
    input  logic              cache_hit,
    input  logic              cache_writeBack,
    input  logic [DATA_W-1:0] cache_dado,
    output logic              busy,
    output logic              grant,
    output logic [7:0]        cnt_hit,
    output logic [7:0]        cnt_miss,
    output logic [7:0]        cnt_wb
);

    estado_t           estado_q, estado_d;
    logic              ptr_q, ptr_d;
    logic              grant_q, grant_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tent_q, tent_d;
    logic [7:0]        espera_q, espera_d;
    logic              erro_q, erro_d;
    logic [DATA_W-1:0] dado0_q, dado0_d;
    logic [DATA_W-1:0] dado1_q, dado1_d;
    logic [DATA_W-1:0] resposta;

    logic valido, vencedor;

    arbitro_rr u_rr (
        .req0     (req0),
        .req1     (req1),
        .ptr      (ptr_q),
        .habilita (estado_q == IDLE),
        .valido   (valido),
        .vencedor (vencedor)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= IDLE;
            ptr_q    <= PORTA0;
            grant_q  <= PORTA0;
            wren_q   <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            tent_q   <= '0;
            espera_q <= '0;
            erro_q   <= 1'b0;
            dado0_q  <= '0;
            dado1_q  <= '0;
        end else begin
            estado_q <= estado_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            wren_q   <= wren_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            tent_q   <= tent_d;
            espera_q <= espera_d;
            erro_q   <= erro_d;
            dado0_q  <= dado0_d;
            dado1_q  <= dado1_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        wren_d   = wren_q;
        data_d   = data_q;
        addr_d   = addr_q;
        tent_d   = tent_q;
        espera_d = espera_q;
        erro_d   = erro_q;
        dado0_d  = dado0_q;
        dado1_d  = dado1_q;
        resposta = wren_q ? data_q : cache_dado;

        case (estado_q)
            IDLE: begin
                if (valido) begin
                    grant_d  = vencedor;
                    wren_d   = (vencedor == PORTA1) ? wren1    : wren0;
                    data_d   = (vencedor == PORTA1) ? data1    : data0;
                    addr_d   = (vencedor == PORTA1) ? address1 : address0;
                    tent_d   = 8'd1;
                    erro_d   = 1'b0;
                    estado_d = ACESSO;
                end
            end
            ACESSO: begin
                // The retry limit is checked before write-back so a dirty miss cannot extend it.
                if (cache_hit || tent_q == 8'(MAX_TENT)) begin
                    estado_d = RESPOSTA;
                    erro_d   = ~cache_hit;
                    if (!cache_hit) begin
                        resposta = '0;
                    end
                    if (grant_q == PORTA1) begin
                        dado1_d = resposta;
                    end else begin
                        dado0_d = resposta;
                    end
                end else if (cache_writeBack) begin
                    estado_d = ESPERA_WB;
                    espera_d = 8'(WB_LAT - 1);
                end else begin
                    estado_d = ESPERA_MISS;
                    espera_d = 8'(MISS_LAT - 1);
                end
            end
            ESPERA_WB: begin
                if (espera_q == 8'd0) begin
                    estado_d = ESPERA_MISS;
                    espera_d = 8'(MISS_LAT - 1);
                end else begin
                    espera_d = espera_q - 8'd1;
                end
            end
            ESPERA_MISS: begin
                if (espera_q == 8'd0) begin
                    estado_d = ACESSO;
                    tent_d   = tent_q + 8'd1;
                end else begin
                    espera_d = espera_q - 8'd1;
                end
            end
            RESPOSTA: begin
                ptr_d    = ~grant_q;
                erro_d   = 1'b0;
                estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (estado_q != IDLE);
        ack0          = (estado_q == RESPOSTA) && (grant_q == PORTA0);
        ack1          = (estado_q == RESPOSTA) && (grant_q == PORTA1);
        erro          = erro_q;
        dadoCPU0      = dado0_q;
        dadoCPU1      = dado1_q;
        grant         = grant_q;
        cache_wren    = busy & wren_q;
        cache_data    = data_q;
        cache_address = addr_q;
    end

`ifdef ARBITRO_CONTADORES_EN
    logic [7:0] cnt_hit_q, cnt_miss_q, cnt_wb_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_hit_q  <= '0;
            cnt_miss_q <= '0;
            cnt_wb_q   <= '0;
        end else if (estado_q == ACESSO) begin
            if (cache_hit) begin
                cnt_hit_q <= sat_inc8(cnt_hit_q);
            end else begin
                cnt_miss_q <= sat_inc8(cnt_miss_q);
                if (cache_writeBack) begin
                    cnt_wb_q <= sat_inc8(cnt_wb_q);
                end
            end
        end
    end

    assign cnt_hit  = cnt_hit_q;
    assign cnt_miss = cnt_miss_q;
    assign cnt_wb   = cnt_wb_q;
`else
    assign cnt_hit  = '0;
    assign cnt_miss = '0;
    assign cnt_wb   = '0;
`endif

endmodule

// File: tb/tb_arbitro_cache.sv
// Randomized self-checking bench for arbitro_cache against a latency/arbitration model.
module tb_arbitro_cache;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 3;
    localparam int MISS_LAT = 2;
    localparam int WB_LAT   = 2;
    localparam int MAX_TENT = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, req1, wren0, wren1;
    logic [DATA_W-1:0] data0, data1;
    logic [ADDR_W-1:0] address0, address1;
    logic              ack0, ack1, erro, cache_wren, busy, grant;
    logic [DATA_W-1:0] dadoCPU0, dadoCPU1, cache_data, cache_dado;
    logic [ADDR_W-1:0] cache_address;
    logic              cache_hit, cache_writeBack;
    logic [7:0]        cnt_hit, cnt_miss, cnt_wb;

    always #5 clock = ~clock;

    arbitro_cache #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MISS_LAT (MISS_LAT),
        .WB_LAT   (WB_LAT),
        .MAX_TENT (MAX_TENT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req0            (req0),
        .req1            (req1),
        .wren0           (wren0),
        .wren1           (wren1),
        .data0           (data0),
        .data1           (data1),
        .address0        (address0),
        .address1        (address1),
        .ack0            (ack0),
        .ack1            (ack1),
        .dadoCPU0        (dadoCPU0),
        .dadoCPU1        (dadoCPU1),
        .erro            (erro),
        .cache_wren      (cache_wren),
        .cache_data      (cache_data),
        .cache_address   (cache_address),
        .cache_hit       (cache_hit),
        .cache_writeBack (cache_writeBack),
        .cache_dado      (cache_dado),
        .busy            (busy),
        .grant           (grant),
        .cnt_hit         (cnt_hit),
        .cnt_miss        (cnt_miss),
        .cnt_wb          (cnt_wb)
    );

    int errors = 0;
    int checks = 0;
    int hit_m = 0, miss_m = 0, wb_m = 0;
    bit ptr_m = 1'b0;

    function automatic logic [7:0] exp_cnt(input int v);
`ifdef ARBITRO_CONTADORES_EN
        return (v > 255) ? 8'd255 : 8'(v);
`else
        return (v < 0) ? 8'd1 : 8'd0;
`endif
    endfunction

    // One transaction of port p; the cache answers with `misses` misses before a hit
    // (or only misses when misses >= MAX_TENT). The other port's request is left untouched.
    task automatic run_txn(input bit p, input bit wr, input logic [DATA_W-1:0] d,
                           input logic [ADDR_W-1:0] a, input int misses,
                           input logic [7:0] wbmask, input logic [DATA_W-1:0] dado_hit);
        int att[$];
        int c, n_att, expc, k;
        bit err, ackp, acko;
        logic [DATA_W-1:0] exp_data, got_data;
        err   = (misses >= MAX_TENT);
        n_att = err ? MAX_TENT : misses + 1;
        c = 1;
        for (int i = 0; i < n_att; i++) begin
            att.push_back(c);
            c += 1 + (wbmask[i] ? WB_LAT : 0) + MISS_LAT;
        end
        expc = att[n_att-1] + 1;
        for (int i = 0; i < n_att; i++) begin
            if (!err && i == n_att - 1) hit_m++;
            else begin
                miss_m++;
                if (wbmask[i]) wb_m++;
            end
        end
        exp_data = err ? '0 : (wr ? d : dado_hit);

        if (p) begin req1 = 1'b1; wren1 = wr; data1 = d; address1 = a; end
        else   begin req0 = 1'b1; wren0 = wr; data0 = d; address0 = a; end

        for (int t = 0; t <= expc; t++) begin
            k = -1;
            foreach (att[i]) if (att[i] == t) k = i;
            if (k >= 0) begin
                cache_hit       = (!err && k == n_att - 1);
                cache_writeBack = wbmask[k];
                cache_dado      = cache_hit ? dado_hit : DATA_W'($urandom);
            end else begin
                cache_hit       = 1'($urandom);
                cache_writeBack = 1'($urandom);
                cache_dado      = DATA_W'($urandom);
            end
            @(negedge clock);
            ackp     = p ? ack1 : ack0;
            acko     = p ? ack0 : ack1;
            got_data = p ? dadoCPU1 : dadoCPU0;

            checks++;
            if (busy !== (t > 0)) begin
                errors++; $display("FAIL busy p=%0d t=%0d got=%b exp=%b", p, t, busy, t > 0);
            end
            checks++;
            if (cache_wren !== ((t > 0) && wr)) begin
                errors++; $display("FAIL cache_wren p=%0d t=%0d got=%b exp=%b", p, t, cache_wren, (t > 0) && wr);
            end
            checks++;
            if (ackp !== (t == expc)) begin
                errors++; $display("FAIL ack_owner p=%0d t=%0d got=%b exp=%b (ack cycle %0d)", p, t, ackp, t == expc, expc);
            end
            checks++;
            if (acko !== 1'b0) begin
                errors++; $display("FAIL ack_other p=%0d t=%0d got=%b exp=0", p, t, acko);
            end
            checks++;
            if (erro !== (t == expc && err)) begin
                errors++; $display("FAIL erro p=%0d t=%0d got=%b exp=%b", p, t, erro, t == expc && err);
            end
            if (t > 0) begin
                checks++;
                if (cache_address !== a || cache_data !== d || grant !== p) begin
                    errors++;
                    $display("FAIL latched p=%0d t=%0d addr=%b/%b data=%b/%b grant=%b/%b (got/exp)",
                             p, t, cache_address, a, cache_data, d, grant, p);
                end
            end
            if (t == expc) begin
                checks++;
                if (got_data !== exp_data) begin
                    errors++; $display("FAIL dadoCPU p=%0d got=%b exp=%b", p, got_data, exp_data);
                end
                checks++;
                if (cnt_hit !== exp_cnt(hit_m) || cnt_miss !== exp_cnt(miss_m) || cnt_wb !== exp_cnt(wb_m)) begin
                    errors++;
                    $display("FAIL counters hit=%0d/%0d miss=%0d/%0d wb=%0d/%0d (got/exp)",
                             cnt_hit, exp_cnt(hit_m), cnt_miss, exp_cnt(miss_m), cnt_wb, exp_cnt(wb_m));
                end
            end
            @(posedge clock); #1;
        end
        if (p) req1 = 1'b0; else req0 = 1'b0;
        ptr_m = ~p;
    endtask

    // Both ports raise requests in the same cycle; the model's pointer picks the winner.
    task automatic sim_pair(input bit wr0, input logic [DATA_W-1:0] d0, input logic [ADDR_W-1:0] a0,
                            input bit wr1, input logic [DATA_W-1:0] d1, input logic [ADDR_W-1:0] a1,
                            input int m0, input int m1);
        bit w;
        w = ptr_m;
        if (w) begin req0 = 1'b1; wren0 = wr0; data0 = d0; address0 = a0; end
        else   begin req1 = 1'b1; wren1 = wr1; data1 = d1; address1 = a1; end
        if (w) begin
            run_txn(1'b1, wr1, d1, a1, m1, 8'($urandom), DATA_W'($urandom));
            run_txn(1'b0, wr0, d0, a0, m0, 8'($urandom), DATA_W'($urandom));
        end else begin
            run_txn(1'b0, wr0, d0, a0, m0, 8'($urandom), DATA_W'($urandom));
            run_txn(1'b1, wr1, d1, a1, m1, 8'($urandom), DATA_W'($urandom));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wren0 = 1'b0; wren1 = 1'b0;
        data0 = '0; data1 = '0; address0 = '0; address1 = '0;
        cache_hit = 1'b0; cache_writeBack = 1'b0; cache_dado = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({ack0, ack1, erro, busy, grant, cache_wren} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000", {ack0, ack1, erro, busy, grant, cache_wren});
        end
        checks++;
        if (cache_data !== '0 || cache_address !== '0 || dadoCPU0 !== '0 || dadoCPU1 !== '0) begin
            errors++; $display("FAIL reset_data data=%b addr=%b d0=%b d1=%b exp=0", cache_data, cache_address, dadoCPU0, dadoCPU1);
        end
        checks++;
        if ({cnt_hit, cnt_miss, cnt_wb} !== 24'd0) begin
            errors++; $display("FAIL reset_cnt got=%h exp=0", {cnt_hit, cnt_miss, cnt_wb});
        end
        @(posedge clock); #1;
        ptr_m = 1'b0; hit_m = 0; miss_m = 0; wb_m = 0;
    endtask

    task automatic test_hit();
        run_txn(1'b0, 1'b0, 3'b010, 5'b10000, 0, 8'h00, 3'd3);
    endtask

    task automatic test_miss_hit();
        run_txn(1'b0, 1'b0, DATA_W'($urandom), 5'b00001, 1, 8'h00, DATA_W'($urandom));
    endtask

    task automatic test_wb_write();
        run_txn(1'b1, 1'b1, 3'b101, 5'b00001, 1, 8'h01, DATA_W'($urandom));
    endtask

    task automatic test_simultaneous();
        sim_pair(1'b0, DATA_W'($urandom), 5'b00101, 1'b1, 3'b100, 5'b01001, 0, 0);
    endtask

    task automatic test_erro();
        run_txn(1'b0, 1'b0, DATA_W'($urandom), ADDR_W'($urandom), MAX_TENT, 8'($urandom), DATA_W'($urandom));
        run_txn(1'b1, 1'b1, 3'b111, ADDR_W'($urandom), MAX_TENT, 8'($urandom), DATA_W'($urandom));
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; wren0 = 1'b1; data0 = DATA_W'($urandom); address0 = ADDR_W'($urandom);
        for (int t = 0; t < 4; t++) begin
            cache_hit = (t == 1) ? 1'b0 : 1'($urandom);
            cache_writeBack = (t == 1) ? 1'b0 : 1'($urandom);
            if (t == 2) reset = 1'b1;
            if (t == 3) begin reset = 1'b0; req0 = 1'b0; end
            @(negedge clock);
            checks++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                errors++; $display("FAIL reset_mid_ack t=%0d got=%b%b exp=00", t, ack0, ack1);
            end
            checks++;
            if (busy !== (t == 1 || t == 2) || cache_wren !== (t == 1 || t == 2)) begin
                errors++; $display("FAIL reset_mid_busy t=%0d busy=%b wren=%b exp=%b", t, busy, cache_wren, t == 1 || t == 2);
            end
            @(posedge clock); #1;
        end
        ptr_m = 1'b0; hit_m = 0; miss_m = 0; wb_m = 0;
        sim_pair(1'b0, DATA_W'($urandom), ADDR_W'($urandom), 1'b1, DATA_W'($urandom), ADDR_W'($urandom), 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                sim_pair(1'($urandom), DATA_W'($urandom), ADDR_W'($urandom),
                         1'($urandom), DATA_W'($urandom), ADDR_W'($urandom),
                         $urandom_range(0, MAX_TENT), $urandom_range(0, MAX_TENT));
            end else begin
                run_txn(1'($urandom), 1'($urandom), DATA_W'($urandom), ADDR_W'($urandom),
                        $urandom_range(0, MAX_TENT), 8'($urandom), DATA_W'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss_hit();
        test_wb_write();
        test_simultaneous();
        test_erro();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
